axi_write_slave: RTL and testbench

AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

---
 rtl/axi_write_slave_pkg.sv | 24 ++
 rtl/axi_wr_addr_gen.sv | 55 +++++
 rtl/axi_write_slave.sv | 137 +++++++++++++
 tb/tb_axi_write_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_write_slave_pkg.sv
// Shared encodings for the AXI write slave: FSM states, BRESP, burst and size codes.
package axi_write_slave_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'b001,
        StWriteData = 3'b010,
        StResponse  = 3'b100
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_4B = 3'b010;

    // Bursts this slave cannot service: anything other than 4-byte beats, or WRAP/reserved.
    function automatic logic unsupported_cfg(logic [2:0] size, logic [1:0] burst);
        return (size != SIZE_4B) || burst[1];
    endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Word-address and beat tracker for one write burst; loaded on AW acceptance,
// advanced on each W handshake.
module axi_wr_addr_gen
    import axi_write_slave_pkg::*;
#(
    parameter int unsigned MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [MEM_AW-1:0] start_addr,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    input  logic              advance,
    output logic [MEM_AW-1:0] word_addr,
    output logic              last_beat,
    output logic              exceeded
);

    logic [MEM_AW-1:0] addr_q;
    logic [3:0]        beat_q;
    logic [3:0]        len_q;
    logic [1:0]        burst_q;
    logic              over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            over_q  <= 1'b0;
        end else if (load) begin
            addr_q  <= start_addr;
            beat_q  <= '0;
            len_q   <= len;
            burst_q <= burst;
            over_q  <= 1'b0;
        end else if (advance) begin
            beat_q <= beat_q + 4'd1;
            // Sticky so a 4-bit wrap of the counter cannot re-enable writes.
            if (beat_q == len_q) begin
                over_q <= 1'b1;
            end
            if (burst_q == BURST_INCR) begin
                addr_q <= addr_q + MEM_AW'(1);
            end
        end
    end

    assign word_addr = addr_q;
    assign exceeded  = over_q;
    assign last_beat = (beat_q == len_q) && !over_q;

endmodule

// File: rtl/axi_write_slave.sv
// Single-outstanding AXI write slave into a word-addressed SRAM, INCR and FIXED
// bursts of 4-byte beats, with DECERR/SLVERR reporting.
module axi_write_slave
    import axi_write_slave_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   awid_m_inf,
    input  logic [ADDR_WIDTH-1:0] awaddr_m_inf,
    input  logic [2:0]            awsize_m_inf,
    input  logic [1:0]            awburst_m_inf,
    input  logic [3:0]            awlen_m_inf,
    input  logic                  awvalid_m_inf,
    output logic                  awready_s_inf,
    input  logic [DATA_WIDTH-1:0] wdata_m_inf,
    input  logic                  wlast_m_inf,
    input  logic                  wvalid_m_inf,
    output logic                  wready_s_inf,
    output logic [ID_WIDTH-1:0]   bid_s_inf,
    output logic [1:0]            bresp_s_inf,
    output logic                  bvalid_s_inf,
    input  logic                  bready_m_inf,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    state_e state_q, state_d;

    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  decerr_q, cfg_err_q;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we_q;
    logic [MEM_AW-1:0]     mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic              aw_hs, w_hs, b_hs;
    logic              decerr_in;
    logic [MEM_AW-1:0] word_addr;
    logic              last_beat, exceeded;
    logic              unused_addr_lsb;

    assign aw_hs = awvalid_m_inf && awready_q;
    assign w_hs  = wvalid_m_inf && wready_q;
    assign b_hs  = bvalid_q && bready_m_inf;

    assign decerr_in       = (awaddr_m_inf >> (MEM_AW + 2)) != '0;
    assign unused_addr_lsb = ^awaddr_m_inf[1:0];

    axi_wr_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (aw_hs),
        .start_addr (awaddr_m_inf[MEM_AW+1:2]),
        .len        (awlen_m_inf),
        .burst      (awburst_m_inf),
        .advance    (w_hs),
        .word_addr  (word_addr),
        .last_beat  (last_beat),
        .exceeded   (exceeded)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (aw_hs) state_d = StWriteData;
            StWriteData: if (w_hs && wlast_m_inf) state_d = StResponse;
            StResponse:  if (b_hs) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        bresp_d = bresp_q;
        if (w_hs && wlast_m_inf) begin
            if (decerr_q) begin
                bresp_d = RESP_DECERR;
            end else if (cfg_err_q || !last_beat) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
            end
        end
    end

    // Handshake outputs are flopped from state_d so awready stays low during reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            id_q        <= '0;
            decerr_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            bresp_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= (state_d == StIdle);
            wready_q  <= (state_d == StWriteData);
            bvalid_q  <= (state_d == StResponse);
            bresp_q   <= bresp_d;
            if (aw_hs) begin
                id_q      <= awid_m_inf;
                decerr_q  <= decerr_in;
                cfg_err_q <= unsupported_cfg(awsize_m_inf, awburst_m_inf);
            end
            mem_we_q <= w_hs && !decerr_q && !cfg_err_q && !exceeded;
            if (w_hs) begin
                mem_addr_q  <= word_addr;
                mem_wdata_q <= wdata_m_inf;
            end
        end
    end

    assign awready_s_inf = awready_q;
    assign wready_s_inf  = wready_q;
    assign bvalid_s_inf  = bvalid_q;
    assign bid_s_inf     = id_q;
    assign bresp_s_inf   = bresp_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_axi_write_slave.sv
// Table-driven bench for axi_write_slave with a scoreboard of expected SRAM writes.
module tb_axi_write_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    axi_write_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .awid_m_inf    (awid),
        .awaddr_m_inf  (awaddr),
        .awsize_m_inf  (awsize),
        .awburst_m_inf (awburst),
        .awlen_m_inf   (awlen),
        .awvalid_m_inf (awvalid),
        .awready_s_inf (awready),
        .wdata_m_inf   (wdata),
        .wlast_m_inf   (wlast),
        .wvalid_m_inf  (wvalid),
        .wready_s_inf  (wready),
        .bid_s_inf     (bid),
        .bresp_s_inf   (bresp),
        .bvalid_s_inf  (bvalid),
        .bready_m_inf  (bready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nbeats;
        logic [31:0] dbase;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wr_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every mem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(e.addr));
                check("write_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    function automatic logic writes_ok(input vec_t v);
        return ((v.addr >> 10) == 0) && (v.size == 3'd2) && !v.burst[1];
    endfunction

    function automatic logic [7:0] model_addr(input vec_t v, input int i);
        logic [7:0] start;
        start = v.addr[9:2];
        return (v.burst == 2'b00) ? start : 8'(start + 8'(i));
    endfunction

    task automatic run_burst(input vec_t v, input int bp);
        int n;
        int exp_cnt;
        int seen0;
        exp_cnt = 0;
        seen0   = wr_seen;
        awid    = v.id;
        awaddr  = v.addr;
        awlen   = v.len;
        awsize  = v.size;
        awburst = v.burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!awready) begin
            check("aw_timeout", 64'(awready), 64'd1);
            awvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int i = 0; i < v.nbeats; i++) begin
            wvalid = 1'b1;
            wdata  = v.dbase + 32'(i);
            wlast  = (i == v.nbeats - 1);
            n = 0;
            while (!wready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!wready) begin
                check("w_timeout", 64'(wready), 64'd1);
                wvalid = 1'b0;
                return;
            end
            if (writes_ok(v) && i <= int'(v.len)) begin
                exp_q.push_back('{addr: model_addr(v, i), data: v.dbase + 32'(i)});
                exp_cnt++;
            end
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            check("b_timeout", 64'(bvalid), 64'd1);
            return;
        end
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_bvalid", 64'(bvalid), 64'd1);
            check("bp_bid", 64'(bid), 64'(v.id));
            check("bp_bresp", 64'(bresp), 64'(v.exp_resp));
            check("bp_awready", 64'(awready), 64'd0);
        end
        check("bresp", 64'(bresp), 64'(v.exp_resp));
        check("bid", 64'(bid), 64'(v.id));
        check("awready_in_resp", 64'(awready), 64'd0);
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        check("bvalid_after_b", 64'(bvalid), 64'd0);
        check("awready_after_b", 64'(awready), 64'd1);
        check("write_count", 64'(wr_seen - seen0), 64'(exp_cnt));
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vec_t v;
        vecs[0] = '{4'h5, 32'h10,  4'd3, 3'd2, 2'b01, 4, 32'hA0, 2'b00};  // INCR 4..7
        vecs[1] = '{4'h6, 32'h20,  4'd2, 3'd2, 2'b00, 3, 32'hC0, 2'b00};  // FIXED at 8
        vecs[2] = '{4'h7, 32'h30,  4'd3, 3'd2, 2'b01, 2, 32'hD0, 2'b10};  // early wlast
        vecs[3] = '{4'h8, 32'h400, 4'd1, 3'd2, 2'b01, 2, 32'hE0, 2'b11};  // out of range
        vecs[4] = '{4'h9, 32'h40,  4'd1, 3'd1, 2'b01, 2, 32'hF0, 2'b10};  // bad size
        vecs[5] = '{4'hA, 32'h40,  4'd1, 3'd2, 2'b10, 2, 32'h50, 2'b10};  // WRAP
        vecs[6] = '{4'hB, 32'h3F8, 4'd3, 3'd2, 2'b01, 4, 32'h60, 2'b00};  // addr wrap
        vecs[7] = '{4'hC, 32'h80,  4'd1, 3'd2, 2'b01, 3, 32'h70, 2'b10};  // extra beat
        vecs[8] = '{4'hD, 32'h800, 4'd0, 3'd0, 2'b01, 1, 32'h90, 2'b11};  // DECERR wins

        rst_n = 1'b0; awid = '0; awaddr = '0; awsize = '0; awburst = '0; awlen = '0;
        awvalid = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        check("rst_bid", 64'(bid), 64'd0);
        check("rst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
        rst_n = 1'b1;
        #1 check("awready_before_edge", 64'(awready), 64'd0);
        @(posedge clk);
        #1 check("awready_after_release", 64'(awready), 64'd1);

        // W beats offered in IDLE must be ignored.
        wvalid = 1'b1; wlast = 1'b1; wdata = 32'hDEAD;
        repeat (3) @(negedge clk);
        check("idle_w_wready", 64'(wready), 64'd0);
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        check("idle_w_bvalid", 64'(bvalid), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i], 0);
            @(negedge clk);
        end

        // Backpressure: hold bready low 5 cycles.
        v = '{4'h3, 32'h44, 4'd0, 3'd2, 2'b01, 1, 32'hB0, 2'b00};
        run_burst(v, 5);
        @(negedge clk);

        // Reset after beat 2 of 4: only two writes, no response.
        awid = 4'h2; awaddr = 32'h50; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'h11 + 32'(i); wlast = 1'b0;
            exp_q.push_back('{addr: 8'(8'h14 + 8'(i)), data: 32'h11 + 32'(i)});
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_awready", 64'(awready), 64'd0);
        check("midrst_wready", 64'(wready), 64'd0);
        check("midrst_bvalid", 64'(bvalid), 64'd0);
        check("midrst_b", 64'({bid, bresp}), 64'd0);
        check("midrst_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
        check("midrst_pending_writes", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        @(posedge clk);
        #1 check("midrst_awready_release", 64'(awready), 64'd1);
        n0 = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid) n0++;
        end
        bready = 1'b0;
        check("midrst_no_b", 64'(n0), 64'd0);

        // Recovery burst after reset.
        run_burst(vecs[0], 0);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
